// File: rtl/interface_demux.sv
// interface_demux: pulls descriptors and payload bytes from the backend FIFOs
// and fans each frame out to the TX ports selected by the descriptor mask.
// One frame is in flight at a time. Frames with an empty mask are read and
// discarded and counted in drop_cnt. Zero-length descriptors are consumed
// without touching the data FIFO.
module interface_demux #(
  parameter int NUM_PORTS = 4
) (
  input  logic                 clk_sys,
  input  logic                 rstn_sys,
  input  logic                 ptr_sfifo_empty,
  output logic                 ptr_sfifo_rd,
  input  logic [19:0]          ptr_sfifo_dout,
  output logic                 sfifo_rd,
  input  logic [7:0]           sfifo_dout,
  input  logic [NUM_PORTS-1:0] tx_data_afull,
  input  logic [NUM_PORTS-1:0] tx_ptr_full,
  output logic [NUM_PORTS-1:0] tx_data_wr,
  output logic [7:0]           tx_data_din,
  output logic [NUM_PORTS-1:0] tx_ptr_wr,
  output logic [15:0]          tx_ptr_din,
  output logic [15:0]          drop_cnt
);

  typedef enum logic [2:0] {
    IDLE, PTR_RD, PTR_LAT, WAIT, DATA, TAIL, PTR_WR
  } state_t;

  state_t                 state;
  logic [NUM_PORTS-1:0]   mask_r;
  logic [10:0]            len_r;
  logic [3:0]             class_r;
  logic [10:0]            cnt;
  logic                   tail_r;
  logic                   arm_r;     // holds off the first descriptor read by one edge after reset
  logic [0:0]             vld_pipe;  // sfifo_dout holds a byte read last cycle
  logic [NUM_PORTS-1:0]   port_busy;

  // A port only blocks the frame if it is a destination and cannot take it.
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_busy
    assign port_busy[i] = mask_r[i] & (tx_data_afull[i] | tx_ptr_full[i]);
  end

  // Frame sequencer with registered strobes, plus the 2-cycle data path
  // (read strobe -> FIFO output -> registered TX byte).
  always_ff @(posedge clk_sys or negedge rstn_sys) begin
    if (!rstn_sys) begin
      state        <= IDLE;
      mask_r       <= '0;
      len_r        <= '0;
      class_r      <= '0;
      cnt          <= '0;
      tail_r       <= 1'b0;
      arm_r        <= 1'b0;
      vld_pipe     <= '0;
      ptr_sfifo_rd <= 1'b0;
      sfifo_rd     <= 1'b0;
      tx_data_wr   <= '0;
      tx_data_din  <= '0;
      tx_ptr_wr    <= '0;
      tx_ptr_din   <= '0;
      drop_cnt     <= '0;
    end else begin
      arm_r        <= 1'b1;
      vld_pipe[0]  <= sfifo_rd;
      // mask_r is stable for the whole frame, so dropped frames write nothing
      tx_data_wr   <= vld_pipe[0] ? mask_r : '0;
      if (vld_pipe[0]) tx_data_din <= sfifo_dout;
      ptr_sfifo_rd <= 1'b0;
      tx_ptr_wr    <= '0;
      case (state)
        IDLE: begin
          if (arm_r && !ptr_sfifo_empty) begin
            state        <= PTR_RD;
            ptr_sfifo_rd <= 1'b1;
          end
        end
        PTR_RD: state <= PTR_LAT;
        PTR_LAT: begin
          class_r <= ptr_sfifo_dout[19:16];
          mask_r  <= ptr_sfifo_dout[15:12];
          len_r   <= ptr_sfifo_dout[10:0];
          state   <= WAIT;
        end
        WAIT: begin
          if (len_r == 11'd0) begin
            state <= IDLE;
          end else if (mask_r == '0) begin
            if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            state    <= DATA;
            sfifo_rd <= 1'b1;
            cnt      <= 11'd1;
          end else if (port_busy == '0) begin
            state    <= DATA;
            sfifo_rd <= 1'b1;
            cnt      <= 11'd1;
          end
        end
        DATA: begin
          // cnt tops out at len_r (<= 2047), so 11 bits never wrap
          if (cnt == len_r) begin
            sfifo_rd <= 1'b0;
            tail_r   <= 1'b0;
            state    <= TAIL;
          end else begin
            cnt <= cnt + 11'd1;
          end
        end
        TAIL: begin
          // two cycles to drain the read pipeline before the descriptor
          if (tail_r) begin
            state      <= PTR_WR;
            tx_ptr_wr  <= mask_r;
            tx_ptr_din <= {class_r, 1'b0, len_r};
          end else begin
            tail_r <= 1'b1;
          end
        end
        PTR_WR: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
